// File: rtl/dcache_types.sv
// Shared types and helpers for the l1_dcache block.
package dcache_types;

  localparam int S_INDEX_DEF  = 3;
  localparam int S_OFFSET_DEF = 5;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    FILL
  } dcache_state_t;

  typedef logic [255:0] dcache_line_t;

  // Replace the enabled byte lanes of one 32-bit word inside a line.
  function automatic dcache_line_t merge_word(input dcache_line_t line,
                                              input logic [2:0]   word_sel,
                                              input logic [31:0]  wdata,
                                              input logic [3:0]   be);
    dcache_line_t res;
    int           base;
    res = line;
    for (int b = 0; b < 4; b++) begin
      base = int'(word_sel) * 32 + b * 8;
      if (be[b]) res[base +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Flop-based line storage: one 256-bit line per set, with a full-line fill
// port and a byte-enabled single-word store port. Read is combinational.
module dcache_data_array
  import dcache_types::*;
#(
  parameter int S_INDEX = S_INDEX_DEF
) (
  input  logic               clk,
  input  logic [S_INDEX-1:0] index,
  input  logic               fill_we,
  input  dcache_line_t       fill_line,
  input  logic               word_we,
  input  logic [2:0]         word_sel,
  input  logic [31:0]        wdata,
  input  logic [3:0]         be,
  output dcache_line_t       rd_line
);

  localparam int SETS = 2 ** S_INDEX;

  dcache_line_t data_q [SETS];
  dcache_line_t data_d [SETS];

  // Next line contents: a fill overrides a store to the same set.
  always_comb begin
    // NOTE: copying the current contents first means every path assigns data_d, so no latch is inferred.
    data_d = data_q;
    if (fill_we) begin
      data_d[index] = fill_line;
    end else if (word_we) begin
      data_d[index] = merge_word(data_q[index], word_sel, wdata, be);
    end
  end

  // Line storage register.
  always_ff @(posedge clk) begin
    // NOTE: data is deliberately not reset; valid bits guard it, and skipping reset keeps the array cheap.
    data_q <= data_d;
  end

  assign rd_line = data_q[index];

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Optional performance counters are enabled with `define DCACHE_PERF_CNT_EN.
module l1_dcache
  import dcache_types::*;
#(
  parameter int S_INDEX  = S_INDEX_DEF,
  parameter int S_OFFSET = S_OFFSET_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  input  logic [3:0]   mem_byte_enable,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
  output logic [31:0]  wb_count
`endif
);

  localparam int S_TAG = 32 - S_INDEX - S_OFFSET;
  localparam int SETS  = 2 ** S_INDEX;

  if (S_OFFSET != 5) begin : g_bad_offset
    $error("l1_dcache: lines are fixed at 256 bits, S_OFFSET must be 5");
  end

  dcache_state_t      state_q, state_d;
  logic [SETS-1:0]    valid_q, valid_d;
  logic [SETS-1:0]    dirty_q, dirty_d;
  logic [S_TAG-1:0]   tag_q [SETS];
  logic [S_TAG-1:0]   tag_d [SETS];

  logic [S_TAG-1:0]   req_tag;
  logic [S_INDEX-1:0] idx;
  logic [2:0]         word;
  logic               req, is_write, hit;
  logic               fill_we, word_we;
  dcache_line_t       rd_line;
  logic               unused_addr_lsb;

  assign req_tag         = mem_address[31 -: S_TAG];
  assign idx             = mem_address[S_OFFSET +: S_INDEX];
  assign word            = mem_address[4:2];
  assign unused_addr_lsb = ^mem_address[1:0];
  assign req             = mem_read | mem_write;
  assign is_write        = mem_write;  // read+write together is handled as a write
  assign hit             = valid_q[idx] && (tag_q[idx] == req_tag);

  dcache_data_array #(.S_INDEX(S_INDEX)) u_data (
    .clk       (clk),
    .index     (idx),
    .fill_we   (fill_we),
    .fill_line (pmem_rdata),
    .word_we   (word_we),
    .word_sel  (word),
    .wdata     (mem_wdata),
    .be        (mem_byte_enable),
    .rd_line   (rd_line)
  );

  // Next-state, metadata updates and all outputs of the miss-handling FSM.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    fill_we      = 1'b0;
    word_we      = 1'b0;
    unique case (state_q)
      CHECK: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            if (is_write) begin
              word_we      = 1'b1;
              dirty_d[idx] = 1'b1;
            end else begin
              mem_rdata = rd_line[{word, 5'b0} +: 32];
            end
          end else begin
            state_d = dirty_q[idx] ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[idx], idx, {S_OFFSET{1'b0}}};
        pmem_wdata   = rd_line;
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, idx, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          fill_we      = 1'b1;
          tag_d[idx]   = req_tag;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = CHECK;
        end
      end
      default: state_d = CHECK;
    endcase
  end

  // State and valid/dirty registers; reset invalidates every line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CHECK;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag storage, meaningful only where valid is set.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic [31:0] wb_count_q, wb_count_d;
  logic        filled_q, filled_d;

  // Saturating event counters; a hit right after a fill is not a first-cycle hit.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    wb_count_d   = wb_count_q;
    filled_d     = (state_q == FILL) && pmem_resp;
    if ((state_q == CHECK) && req && hit && !filled_q && (hit_count_q != '1))
      hit_count_d = hit_count_q + 32'd1;
    if ((state_q == CHECK) && req && !hit && (miss_count_q != '1))
      miss_count_d = miss_count_q + 32'd1;
    if ((state_q == WRITEBACK) && pmem_resp && (wb_count_q != '1))
      wb_count_d = wb_count_q + 32'd1;
  end

  // Counter registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
      filled_q     <= 1'b0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      wb_count_q   <= wb_count_d;
      filled_q     <= filled_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;
`endif

  // Requester protocol checks (simulation only).
  a_no_rd_wr: assert property (@(posedge clk) disable iff (!rst)
    !(mem_read && mem_write));
  a_hold_req: assert property (@(posedge clk) disable iff (!rst)
    (state_q != CHECK) |-> (mem_read || mem_write));

endmodule

// File: tb/tb_l1_dcache.sv
// Directed testbench for l1_dcache with a 2-cycle-latency pmem responder.
module tb_l1_dcache;
  import dcache_types::*;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address, mem_wdata, mem_rdata;
  logic [3:0]   mem_byte_enable;
  logic         mem_resp;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_count, miss_count, wb_count;
`endif

  always #5 clk = ~clk;

  l1_dcache dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count),
    .wb_count        (wb_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Backing memory model, indexed by line address.
  logic [255:0] bk [logic [31:0]];
  int           rd_events = 0;
  int           wr_events = 0;
  int           cnt = 0;
  logic         both_seen = 1'b0;
  logic [31:0]  last_rd_addr = '0;
  logic [31:0]  last_wb_addr = '0;
  logic [255:0] last_wb_data = '0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          cyc;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [$];

  function automatic logic [255:0] dflt_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = (a + 32'(i * 4)) ^ 32'h5A5A_0000;
    return l;
  endfunction

  function automatic logic [255:0] bk_get(input logic [31:0] a);
    if (bk.exists(a)) return bk[a];
    return dflt_line(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // pmem responder: answers each strobe LAT negedges after it first appears.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_read && pmem_write) both_seen = 1'b1;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt       = 0;
      end else if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt == LAT) begin
          pmem_resp = 1'b1;
          if (pmem_read) begin
            pmem_rdata   = bk_get(pmem_address);
            last_rd_addr = pmem_address;
            rd_events++;
          end else begin
            bk[pmem_address] = pmem_wdata;
            last_wb_addr     = pmem_address;
            last_wb_data     = pmem_wdata;
            wr_events++;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic wait_resp(output int cyc, output logic got);
    cyc = 0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_resp) begin
        got = 1'b1;
        break;
      end
      cyc++;
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int exp_cyc, input logic [31:0] exp_rdata, input string name);
    int   cyc;
    logic got;
    @(posedge clk);
    #1;
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_wdata       = wdata;
    mem_byte_enable = be;
    wait_resp(cyc, got);
    check({name, " resp"}, 32'(got), 32'd1);
    check({name, " cycles"}, 32'(cyc), 32'(exp_cyc));
    if (rd) check({name, " rdata"}, mem_rdata, exp_rdata);
    @(posedge clk);
    #1;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
  endtask

  initial begin
    int           ev;
    int           cyc;
    logic         got;
    logic         seen;
    logic [255:0] l40;

    rst             = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;

    l40            = dflt_line(32'h40);
    l40[31:0]      = 32'hDEAD_BEEF;
    l40[63:32]     = 32'h1111_2222;
    bk[32'h40]     = l40;

    // Table of accesses run after the hand-written sequence.
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0148, 32'h0,         4'h0, 0, 32'h5A5A_0148});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_015C, 32'h0102_0304, 4'hF, 0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_015C, 32'h0,         4'h0, 0, 32'h0102_0304});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0150, 32'hFF00_0000, 4'h8, 0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0150, 32'h0,         4'h0, 0, 32'hFF5A_0150});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_1000, 32'h0,         4'h0, 3, 32'h5A5A_1000});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_101C, 32'h0,         4'h0, 0, 32'h5A5A_101C});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_2140, 32'h0,         4'h0, 6, 32'h5A5A_2140});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_015C, 32'h0,         4'h0, 3, 32'h0102_0304});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0150, 32'h0,         4'h0, 0, 32'hFF5A_0150});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_3004, 32'hCAFE_F00D, 4'hF, 3, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_3004, 32'h0,         4'h0, 0, 32'hCAFE_F00D});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_3008, 32'h1234_5678, 4'h0, 0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_3008, 32'h0,         4'h0, 0, 32'h5A5A_3008});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_301C, 32'h0,         4'h0, 0, 32'h5A5A_301C});
    vecs.push_back('{1'b1, 1'b0, 32'hFFFF_FFE0, 32'h0,         4'h0, 3, 32'hA5A5_FFE0});
    vecs.push_back('{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         4'h0, 0, 32'hA5A5_FFFC});

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst mem_resp", 32'(mem_resp), 32'd0);
    check("rst pmem_read", 32'(pmem_read), 32'd0);
    check("rst pmem_write", 32'(pmem_write), 32'd0);
    check("rst state", 32'(dut.state_q), 32'(CHECK));
`ifdef DCACHE_PERF_CNT_EN
    check("rst hit_count", hit_count, 32'd0);
    check("rst miss_count", miss_count, 32'd0);
    check("rst wb_count", wb_count, 32'd0);
`endif
    rst = 1'b1;

    // Cold miss, hit, store hit, dirty eviction.
    access(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, "cold");
    check("cold fill addr", last_rd_addr, 32'h40);
    ev = rd_events + wr_events;
    access(1'b1, 1'b0, 32'h44, 32'h0, 4'h0, 0, 32'h1111_2222, "hit44");
    check("hit44 no pmem", 32'(rd_events + wr_events), 32'(ev));
    access(1'b0, 1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101, 0, 32'h0, "wr40");
    check("wr40 dirty", 32'(dut.dirty_q[2]), 32'd1);
    access(1'b1, 1'b0, 32'h140, 32'h0, 4'h0, 6, 32'h5A5A_0140, "evict");
    check("evict wb addr", last_wb_addr, 32'h40);
    check("evict wb word0", last_wb_data[31:0], 32'hDEBB_BEDD);
    check("evict wb word1", last_wb_data[63:32], 32'h1111_2222);
    check("evict fill addr", last_rd_addr, 32'h140);
`ifdef DCACHE_PERF_CNT_EN
    check("hit_count", hit_count, 32'd2);
    check("miss_count", miss_count, 32'd2);
    check("wb_count", wb_count, 32'd1);
`endif

    // Table-driven accesses.
    foreach (vecs[i]) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
             vecs[i].cyc, vecs[i].rdata, $sformatf("v%0d", i));
    end

    // Idle outputs.
    @(negedge clk);
    check("idle mem_resp", 32'(mem_resp), 32'd0);
    check("idle mem_rdata", mem_rdata, 32'd0);
    check("idle pmem strobes", {30'd0, pmem_read, pmem_write}, 32'd0);

    // Reset asserted while a fill is outstanding.
    @(posedge clk);
    #1;
    mem_read    = 1'b1;
    mem_address = 32'h40;
    seen        = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pmem_read) begin
        seen = 1'b1;
        break;
      end
    end
    check("rstfill seen", 32'(seen), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rstfill pmem_read", 32'(pmem_read), 32'd0);
    check("rstfill state", 32'(dut.state_q), 32'(CHECK));
    check("rstfill mem_resp", 32'(mem_resp), 32'd0);
    rst = 1'b1;
    wait_resp(cyc, got);
    check("reread resp", 32'(got), 32'd1);
    check("reread cycles", 32'(cyc), 32'd2);
    check("reread rdata", mem_rdata, 32'hDEBB_BEDD);
    @(posedge clk);
    #1;
    mem_read    = 1'b0;
    mem_address = '0;

    // Dirty data held at reset is discarded, memory copy returned.
    access(1'b1, 1'b0, 32'h3004, 32'h0, 4'h0, 3, 32'h5A5A_3004, "discard");

    check("pmem exclusive", 32'(both_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
